// File: rtl/amp_boot_seq.sv
// Boot sequencer for the external amplifier: streams a snapshot of the boot bytes
// to the serial byte transmitter and reports ACK/timeout result on status.
module amp_boot_seq #(
  parameter int unsigned N_BYTES     = 8,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned GAP_CYCLES  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   amp_init,
  input  logic [8*N_BYTES-1:0]   bootmem,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  output logic                   tx_last,
  input  logic                   tx_ready,
  input  logic                   tx_done,
  input  logic                   tx_ack_ok,
  output logic [7:0]             status,
  output logic                   busy
);

  localparam int unsigned TMO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [3:0]  LAST_IDX = 4'(N_BYTES - 1);
  localparam logic [3:0]  N_CNT    = 4'(N_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_WAIT, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t                 state_q, state_d;
  logic                   amp_init_q;
  logic [8*N_BYTES-1:0]   shadow_q, shadow_d;
  logic [3:0]             index_q, index_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [7:0]             status_q, status_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_last_q, tx_last_d;
  logic                   start_c;
  logic [3:0]             nxt_idx_c;

  function automatic logic [7:0] pick(input logic [8*N_BYTES-1:0] mem, input logic [3:0] idx);
    logic [7:0] b;
    b = '0;
    for (int unsigned k = 0; k < N_BYTES; k++) begin
      if (idx == 4'(k)) b = mem[8*k +: 8];
    end
    return b;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      amp_init_q <= 1'b0;
      shadow_q   <= '0;
      index_q    <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
      status_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      amp_init_q <= amp_init;
      shadow_q   <= shadow_d;
      index_q    <= index_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      status_q   <= status_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_last_q  <= tx_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    index_d    = index_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    status_d   = status_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_last_d  = tx_last_q;
    start_c    = amp_init & ~amp_init_q;
    nxt_idx_c  = index_q + 4'd1;

    unique case (state_q)
      S_IDLE: begin
        tx_valid_d = 1'b0;
        if (start_c) begin
          state_d  = S_LOAD;
          index_d  = '0;
          status_d = 8'h20;
        end
      end
      S_LOAD: begin
        shadow_d   = bootmem;
        tx_valid_d = 1'b1;
        tx_data_d  = bootmem[7:0];
        tx_last_d  = (LAST_IDX == 4'd0);
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          tmo_d      = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // a tx_done on the timeout cycle still wins over the timeout
        if (tx_done) begin
          if (!tx_ack_ok) begin
            state_d  = S_ERR;
            status_d = {4'b0100, index_q};
          end else if (index_q == LAST_IDX) begin
            state_d  = S_DONE;
            status_d = {4'b1000, N_CNT};
          end else begin
            index_d  = nxt_idx_c;
            status_d = {4'b0010, nxt_idx_c};
            if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              gap_d   = '0;
            end else begin
              state_d    = S_SEND;
              tx_valid_d = 1'b1;
              tx_data_d  = pick(shadow_q, nxt_idx_c);
              tx_last_d  = (nxt_idx_c == LAST_IDX);
            end
          end
        end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          state_d  = S_ERR;
          status_d = {4'b0101, index_q};
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d    = S_SEND;
          tx_valid_d = 1'b1;
          tx_data_d  = pick(shadow_q, index_q);
          tx_last_d  = (index_q == LAST_IDX);
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign status   = status_q;
  assign busy     = status_q[5];

endmodule

// File: tb/tb_amp_boot_seq.sv
// Bench for amp_boot_seq: plays the byte transmitter with random handshakes and
// compares transfers and status against a byte-list model of the boot sequence.
module tb_amp_boot_seq;
  localparam int N   = 8;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        reset, amp_init, tx_ready, tx_done, tx_ack_ok;
  logic [63:0] bootmem;
  logic [7:0]  tx_data, status;
  logic        tx_valid, tx_last, busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] obs_d[$];
  logic       obs_l[$];
  int nxfer, stall_bad, status_bad, tmo_cyc;
  bit finished, rst_hit;

  amp_boot_seq #(.N_BYTES(8), .ACK_TIMEOUT(255), .GAP_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .amp_init(amp_init), .bootmem(bootmem),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_ack_ok(tx_ack_ok),
    .status(status), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] byte_of(input logic [63:0] m, input int i);
    logic [63:0] t;
    t = m >> (8 * i);
    return t[7:0];
  endfunction

  // Transmitter model: records every accepted byte, answers with tx_done after a random delay.
  task automatic serve(input int nak_idx, input int tmo_idx, input int stall_idx,
                       input int poke_idx, input int rst_idx);
    int cnt, cur, stall, tmo_start, poke_ph;
    bit started, prev_wait;
    logic [7:0] prev_d;
    logic prev_l;
    cnt = -1; cur = 0; stall = 0; tmo_start = -1; poke_ph = 0;
    started = 0; prev_wait = 0; prev_d = '0; prev_l = 1'b0;
    obs_d.delete(); obs_l.delete();
    stall_bad = 0; status_bad = 0; tmo_cyc = -1; finished = 0; rst_hit = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      tx_done = 1'b0;
      tx_ack_ok = 1'b0;
      if (poke_ph == 1) begin amp_init = 1'b1; poke_ph = 2; end
      if (busy) started = 1;
      else if (started) begin
        finished = 1;
        if (tmo_start >= 0) tmo_cyc = cyc - tmo_start;
        break;
      end
      if (rst_idx >= 0 && cur == rst_idx + 1) begin rst_hit = 1; break; end
      if (cnt > 0) cnt--;
      if (cnt == 0) begin
        tx_done = 1'b1;
        tx_ack_ok = (cur - 1 != nak_idx);
        cnt = -1;
      end
      if (tx_valid) begin
        if (prev_wait && (tx_data !== prev_d || tx_last !== prev_l)) stall_bad++;
        if (status !== {4'b0010, 4'(cur)}) status_bad++;
        if (cur == stall_idx && stall < 10) begin
          tx_ready = 1'b0;
          stall++;
          if (stall == 4) begin tx_done = 1'b1; tx_ack_ok = 1'b0; end
        end else begin
          tx_ready = ($urandom_range(0, 3) != 0);
        end
        if (tx_ready) begin
          obs_d.push_back(tx_data);
          obs_l.push_back(tx_last);
          cur++;
          prev_wait = 0;
          if (cur - 1 == tmo_idx) tmo_start = cyc;
          else cnt = $urandom_range(1, 8);
          if (cur - 1 == poke_idx) begin
            amp_init = 1'b0;
            bootmem = {$urandom, $urandom};
            poke_ph = 1;
          end
        end else begin
          prev_wait = 1; prev_d = tx_data; prev_l = tx_last;
        end
      end else begin
        prev_wait = 0;
        tx_ready = ($urandom_range(0, 1) != 0);
      end
    end
    nxfer = obs_d.size();
  endtask

  task automatic kick();
    @(negedge clk);
    tx_ready = 1'b0;
    amp_init = 1'b0;
    @(negedge clk);
    amp_init = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; amp_init = 1'b0; tx_ready = 1'b0; tx_done = 1'b0; tx_ack_ok = 1'b0;
    bootmem = '0;
    repeat (3) @(negedge clk);
    checks++; if (status !== 8'h00) begin failures++; $display("FAIL reset_status got=%h exp=00", status); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (tx_valid !== 1'b0 || tx_last !== 1'b0) begin failures++; $display("FAIL reset_tx got=%b%b exp=00", tx_valid, tx_last); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", tx_data); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [63:0] m;
    int lat;
    for (int pass = 0; pass < 2; pass++) begin
      m = (pass == 0) ? 64'h0706050403020100 : {$urandom, $urandom};
      bootmem = m;
      kick();
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (tx_valid) begin lat = i; break; end
      end
      checks++; if (lat != 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", lat); end
      serve(-1, -1, -1, -1, -1);
      checks++; if (!finished || nxfer != N) begin failures++; $display("FAIL basic_count got=%0d fin=%0b exp=%0d", nxfer, finished, N); end
      for (int i = 0; i < nxfer && i < N; i++) begin
        checks++;
        if (obs_d[i] !== byte_of(m, i) || obs_l[i] !== (i == N - 1)) begin
          failures++;
          $display("FAIL basic_byte%0d got=%h/%b exp=%h/%b", i, obs_d[i], obs_l[i], byte_of(m, i), i == N - 1);
        end
      end
      checks++; if (status !== 8'h88 || busy !== 1'b0) begin failures++; $display("FAIL basic_status got=%h/%b exp=88/0", status, busy); end
      checks++; if (stall_bad != 0 || status_bad != 0) begin failures++; $display("FAIL basic_live got=%0d/%0d exp=0/0", stall_bad, status_bad); end
    end
    // amp_init still high: no second sequence may start
    lat = 0;
    repeat (30) begin @(negedge clk); if (busy || tx_valid) lat++; end
    checks++; if (lat != 0) begin failures++; $display("FAIL held_init got=%0d exp=0", lat); end
  endtask

  task automatic test_stall();
    bootmem = 64'h0706050403020100;
    kick();
    serve(-1, -1, 2, -1, -1);
    checks++; if (nxfer != N) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", nxfer, N); end
    checks++; if (nxfer > 2 && obs_d[2] !== 8'h02) begin failures++; $display("FAIL stall_byte2 got=%h exp=02", obs_d[2]); end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", stall_bad); end
    checks++; if (status !== 8'h88) begin failures++; $display("FAIL stall_status got=%h exp=88", status); end
  endtask

  task automatic test_nak();
    logic [63:0] m;
    m = {$urandom, $urandom};
    bootmem = m;
    kick();
    serve(3, -1, -1, -1, -1);
    checks++; if (!finished || nxfer != 4) begin failures++; $display("FAIL nak_count got=%0d exp=4", nxfer); end
    for (int i = 0; i < nxfer && i < 4; i++) begin
      checks++; if (obs_d[i] !== byte_of(m, i)) begin failures++; $display("FAIL nak_byte%0d got=%h exp=%h", i, obs_d[i], byte_of(m, i)); end
    end
    checks++; if (status !== 8'h43) begin failures++; $display("FAIL nak_status got=%h exp=43", status); end
    m = {$urandom, $urandom};
    bootmem = m;
    kick();
    @(negedge clk);
    checks++; if (status !== 8'h20) begin failures++; $display("FAIL nak_restart_status got=%h exp=20", status); end
    serve(-1, -1, -1, -1, -1);
    checks++; if (nxfer < 1 || obs_d[0] !== byte_of(m, 0)) begin failures++; $display("FAIL nak_restart_first got=%h exp=%h", nxfer > 0 ? obs_d[0] : 8'hxx, byte_of(m, 0)); end
    checks++; if (nxfer != N || status !== 8'h88) begin failures++; $display("FAIL nak_restart_end got=%0d/%h exp=%0d/88", nxfer, status, N); end
  endtask

  task automatic test_timeout();
    bootmem = {$urandom, $urandom};
    kick();
    serve(-1, 5, -1, -1, -1);
    checks++; if (nxfer != 6) begin failures++; $display("FAIL tmo_count got=%0d exp=6", nxfer); end
    checks++; if (status !== 8'h55) begin failures++; $display("FAIL tmo_status got=%h exp=55", status); end
    checks++; if (tmo_cyc < TMO || tmo_cyc > TMO + 3) begin failures++; $display("FAIL tmo_cycles got=%0d exp=%0d..%0d", tmo_cyc, TMO, TMO + 3); end
  endtask

  task automatic test_mid_restart();
    logic [63:0] m;
    int extra;
    m = {$urandom, $urandom};
    bootmem = m;
    kick();
    serve(-1, -1, -1, 2, -1);
    checks++; if (nxfer != N) begin failures++; $display("FAIL mid_count got=%0d exp=%0d", nxfer, N); end
    for (int i = 0; i < nxfer && i < N; i++) begin
      checks++; if (obs_d[i] !== byte_of(m, i)) begin failures++; $display("FAIL mid_byte%0d got=%h exp=%h", i, obs_d[i], byte_of(m, i)); end
    end
    checks++; if (status !== 8'h88) begin failures++; $display("FAIL mid_status got=%h exp=88", status); end
    extra = 0;
    repeat (40) begin @(negedge clk); if (busy || tx_valid) extra++; end
    checks++; if (extra != 0) begin failures++; $display("FAIL mid_no_queue got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] m;
    bootmem = {$urandom, $urandom};
    kick();
    serve(-1, -1, -1, -1, 4);
    checks++; if (!rst_hit) begin failures++; $display("FAIL rstmid_reach got=%0b exp=1", rst_hit); end
    reset = 1'b1;
    #1;
    checks++; if (status !== 8'h00 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_status got=%h/%b exp=00/0", status, busy); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", tx_valid); end
    tx_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m = {$urandom, $urandom};
    bootmem = m;
    kick();
    serve(-1, -1, -1, -1, -1);
    checks++; if (nxfer != N || status !== 8'h88) begin failures++; $display("FAIL rstmid_rerun got=%0d/%h exp=%0d/88", nxfer, status, N); end
    for (int i = 0; i < nxfer && i < N; i++) begin
      checks++; if (obs_d[i] !== byte_of(m, i)) begin failures++; $display("FAIL rstmid_byte%0d got=%h exp=%h", i, obs_d[i], byte_of(m, i)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_nak();
    test_timeout();
    test_mid_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
